register_bank: RTL

- Parametrised bank of NUM_REGS general registers, each DATA_W bits wide, for the simple CPU datapath.
- Generalises the single enabled bus register:
  - one-hot load enables (rin) capture from buswires;
  - a one-hot read select drives the shared bus;
  - optional top register acts as program counter with increment;
  - synchronous bank clear.
- Sits between the control FSM and the bus multiplexer.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/reg_cell.sv | 17 +
 rtl/register_bank.sv | 38 +++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath constants and select-vector helpers
package cpu_pkg;
  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;
  function automatic int onehot_count(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/reg_cell.sv
// reg_cell: one bank register with clear > load > increment > hold priority
module reg_cell #(
  parameter int DATA_W  = 16,
  parameter bit HAS_INC = 1'b0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              ld,
  input  logic              inc,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) q <= '0;
    else q <= clear ? '0 : ld ? d : (HAS_INC && inc) ? q + 1'b1 : q;
endmodule

// File: rtl/register_bank.sv
// register_bank: register file with one-hot load/read selects and optional PC on the top register
module register_bank
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter bit PC_EN    = 1'b1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [DATA_W-1:0]          buswires,
  input  logic [NUM_REGS-1:0]        rin,
  input  logic [NUM_REGS-1:0]        rout,
  input  logic                       incr_pc,
  input  logic                       clear,
  output logic [DATA_W-1:0]          bus_out,
  output logic                       bus_valid,
  output logic                       sel_err,
  output logic [DATA_W-1:0]          pc_out,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);
  logic [DATA_W-1:0] q [NUM_REGS];
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    reg_cell #(.DATA_W(DATA_W), .HAS_INC(PC_EN && (g == NUM_REGS-1))) u_cell (
      .clock(clock), .resetn(resetn), .clear(clear), .ld(rin[g]),
      .inc(incr_pc), .d(buswires), .q(q[g])
    );
    assign regs_flat[g*DATA_W +: DATA_W] = q[g];
  end
  // Scan high to low so the lowest selected index wins on multi-select
  always_comb begin
    bus_out = '0;
    for (int i = NUM_REGS-1; i >= 0; i--) if (rout[i]) bus_out = q[i];
  end
  assign bus_valid = |rout;
  assign sel_err   = onehot_count(16'(rout)) > 1;
  assign pc_out    = q[NUM_REGS-1];
endmodule
